// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor:
// the handshake FSM encoding and the bit-counter width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // The counter must index W bit positions; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        if (w <= 1) begin
            return 1;
        end else begin
            return $clog2(w);
        end
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bi, with borrow-out bo.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (D = A - B - Bin), LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add a registered two's-complement overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CNT_W = cnt_width(W);

    sub_state_e     state_r;
    logic [W-1:0]   a_sh_r;
    logic [W-1:0]   b_sh_r;
    logic [W-1:0]   res_r;
    logic           br_r;
    logic [CNT_W-1:0] cnt_r;
    logic           busy_r;
    logic           done_r;
    logic [W-1:0]   d_r;
    logic           bout_r;
`ifdef SERIAL_SUB_OVF_EN
    logic           ovf_r;
`endif

    logic           diff_s;
    logic           bo_s;
    logic           last_s;
    logic [W-1:0]   a_next_s;
    logic [W-1:0]   b_next_s;
    logic [W-1:0]   res_next_s;

    full_subtractor u_fs (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .bi (br_r),
        .d  (diff_s),
        .bo (bo_s)
    );

    // Next values of the shift datapath; the new difference bit enters at the MSB.
    always_comb begin
        a_next_s   = a_sh_r >> 1;
        b_next_s   = b_sh_r >> 1;
        res_next_s = (res_r >> 1) | (W'(diff_s) << (W - 1));
        last_s     = (cnt_r == CNT_W'(W - 1));
    end

    // Handshake FSM with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            res_r   <= '0;
            br_r    <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            d_r     <= '0;
            bout_r  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        br_r    <= bin;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r <= a_next_s;
                    b_sh_r <= b_next_s;
                    res_r  <= res_next_s;
                    br_r   <= bo_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        // Publish the result; d/bout stay put until the next accepted start finishes.
                        d_r     <= res_next_s;
                        bout_r  <= bo_s;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_r   <= br_r ^ bo_s;
`endif
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign d    = d_r;
    assign bout = bout_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=4): scoreboard of expected results
// compared when done pulses, plus handshake timing, back-to-back, and reset checks.
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   n_compared;
    int   n_mismatched;
    exp_t sb_q[$];

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: unsigned (W+1)-bit difference gives borrow; signed integer range gives overflow.
    function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic bin_v);
        exp_t       e;
        logic [W:0] full;
        int         sr;
        full   = {1'b0, a_v} - {1'b0, b_v} - (W + 1)'(bin_v);
        e.d    = full[W-1:0];
        e.bout = full[W];
        sr     = int'($signed(a_v)) - int'($signed(b_v)) - int'(bin_v);
        e.ovf  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check_eq("done_unexpected", done, 1'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("d", d, e.d);
                check_eq("bout", bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
                check_eq("ovf", ovf, e.ovf);
`endif
            end
        end
    end

    // Called at a negedge with the DUT idle or done; returns at the negedge inside the DONE cycle.
    task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic bin_v,
                         input bit poke_mid);
        start = 1'b1;
        a     = a_v;
        b     = b_v;
        bin   = bin_v;
        sb_q.push_back(model(a_v, b_v, bin_v));
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            check_eq("busy_run", busy, 1'b1);
            check_eq("done_run", done, 1'b0);
            if (poke_mid && i == 2) begin
                start = 1'b1;
                a     = ~a_v;
                b     = 4'd7;
                bin   = ~bin_v;
            end
            if (poke_mid && i == 3) start = 1'b0;
        end
        @(negedge clk);
        check_eq("done_latency", done, 1'b1);
        check_eq("busy_done", busy, 1'b0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_d", d, 4'd0);
        check_eq("rst_bout", bout, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        do_op(4'd5, 4'd1, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("hold_d", d, 4'd4);
        check_eq("idle_done", done, 1'b0);
        do_op(4'd1, 4'd2, 1'b0, 1'b0);
        @(negedge clk);
        do_op(4'd0, 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        do_op(4'd15, 4'd15, 1'b0, 1'b0);
        @(negedge clk);
        do_op(4'd8, 4'd1, 1'b0, 1'b0);
        @(negedge clk);
        do_op(4'd3, 4'd1, 1'b0, 1'b0);

        // Back-to-back: start accepted in the DONE cycle.
        do_op(4'd9, 4'd3, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("b2b_hold_d", d, 4'd6);

        // start pulsed mid-run is ignored.
        do_op(4'd12, 4'd5, 1'b1, 1'b1);
        @(negedge clk);

        // Randomised operands.
        for (int k = 0; k < 8; k++) begin
            do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            if (k[0]) @(negedge clk);
        end
        @(negedge clk);

        // Reset during RUN cycle 2 discards the operation.
        start = 1'b1;
        a     = 4'd14;
        b     = 4'd3;
        bin   = 1'b0;
        sb_q.push_back(model(4'd14, 4'd3, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_done", done, 1'b0);
        check_eq("midrst_d", d, 4'd0);
        check_eq("midrst_bout", bout, 1'b0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check_eq("midrst_no_done", done, 1'b0);
        end

        // Operation after reset recovery.
        do_op(4'd6, 4'd2, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor that computes D = A - B - Bin, one bit per clock, LSB first.
- Each bit is handled by a single full-subtractor stage with a registered borrow; it is the inverse-direction counterpart of the team's ripple adder datapath.
- Sits on the arithmetic path where area matters more than latency.
- Uses a start/busy/done handshake toward the controlling FSM.

Parameters:
- W, 4, operand and result width in bits; W >= 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while the block is idle or done.
- a  input  W  minuend; captured on an accepted start.
- b  input  W  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- d  output  W  difference; held stable from done until the next accepted start.
- bout  output  1  final borrow-out; 1 when A < B + Bin (unsigned).

Behaviour:
- Reset: with rst high at a clock edge, state <= IDLE and busy = 0, done = 0, d = 0, bout = 0. The internal shift registers, borrow register and bit counter are all cleared. Reset wins over every other input, including mid-operation; a partially computed result is discarded and no done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 -> capture a, b and bin into the shift registers and borrow register; counter <= 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy = 1):
  - Each cycle, the full subtractor takes the LSB of the A and B shift registers plus the borrow register.
  - Difference bit = a^b^br.
  - Borrow = (~a&b) | (~(a^b)&br).
  - The difference bit is shifted into the MSB of the result register; the A and B registers shift right; the borrow register updates; the counter increments.
  - When counter == W-1 in this cycle, go to DONE.
  - start is ignored while in RUN.
- DONE (done = 1 for exactly this cycle, busy = 0):
  - d and bout are valid and hold their values through the following IDLE cycles.
  - start = 1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted at cycle edge 0 -> done high during cycle W+1, i.e. W RUN cycles plus one DONE cycle. Throughput is one result per W+1 cycles.
- Widths: the counter is clog2(W) bits, minimum 1. All arithmetic is modulo 2^W; wrap-around is reported only through bout.
- W = 1: exactly one RUN cycle, then DONE.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined, an extra output port ovf (1 bit) is added; it resets to 0. Two's-complement overflow is registered as the borrow into the MSB XOR the borrow out of the MSB, computed in the final RUN cycle. ovf is valid alongside done and held with d.
- When undefined, the port and its logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum (IDLE, RUN, DONE), 2-bit encoding.
  - localparam function for the counter width.
- One natural sub-module: full_subtractor (inputs a, b, bi; outputs d, bo), purely combinational, instantiated once.

Test Plan:
- W=4, rst held for 2 cycles -> busy = 0, done = 0, d = 0, bout = 0.
- a=5, b=1, bin=0, start pulse -> busy for 4 cycles, done in cycle 5, d = 4, bout = 0.
- a=1, b=2, bin=0 -> d = 15, bout = 1.
- a=0, b=0, bin=1 -> d = 15, bout = 1.
- a=15, b=15, bin=0 -> d = 0, bout = 0.
- Back-to-back and robustness:
  - start asserted in the DONE cycle with a=9, b=3 -> second done exactly 5 cycles later, d = 6.
  - start pulsed during RUN -> ignored, first result unaffected.
  - rst asserted during RUN cycle 2 -> outputs 0, no done pulse.
- With SERIAL_SUB_OVF_EN:
  - a=8 (-8), b=1 -> d = 7, ovf = 1.
  - a=3, b=1 -> d = 2, ovf = 0.
